// File: rtl/mux4_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a downstream mux4.
// Grants one of four requesters at a time, limiting tenure to MAX_HOLD cycles under contention.
module mux4_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       switched
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    last;

  logic [3:0]    others;
  logic [3:0]    cand;
  logic [1:0]    base;
  logic [1:0]    winner;
  logic          at_max;

  // First requesting index at or after base, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] b);
    logic [1:0] p;
    logic       found;
    p     = b;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!found && r[b + 2'(k)]) begin
        p     = b + 2'(k);
        found = 1'b1;
      end
    end
    return p;
  endfunction

  always_comb begin
    others = req & ~(4'b0001 << sel);
    at_max = (hold_cnt == HW'(MAX_HOLD));
    cand   = (state == IDLE) ? req : others;
    base   = (state == IDLE) ? last + 2'd1 : sel + 2'd1;
    winner = rr_pick(cand, base);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      gnt      <= '0;
      valid    <= 1'b0;
      switched <= 1'b0;
      hold_cnt <= '0;
      last     <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            sel      <= winner;
            gnt      <= 4'b0001 << winner;
            valid    <= 1'b1;
            switched <= 1'b1;
            hold_cnt <= HW'(1);
            last     <= winner;
          end else begin
            gnt      <= '0;
            valid    <= 1'b0;
            switched <= 1'b0;
          end
        end
        GRANT: begin
          // Release and expiry both hand over directly to the next requester.
          if ((|others) && (!req[sel] || at_max)) begin
            sel      <= winner;
            gnt      <= 4'b0001 << winner;
            valid    <= 1'b1;
            switched <= 1'b1;
            hold_cnt <= HW'(1);
            last     <= winner;
          end else if (!req[sel]) begin
            state    <= IDLE;
            gnt      <= '0;
            valid    <= 1'b0;
            switched <= 1'b0;
            hold_cnt <= '0;
          end else begin
            switched <= 1'b0;
            if (!at_max) hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Self-checking bench for mux4_sel_arbiter: per-cycle model comparison plus directed literal checks.
module tb_mux4_sel_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic       switched;

  int checks   = 0;
  int failures = 0;

  mux4_sel_arbiter #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel),
    .gnt(gnt), .valid(valid), .switched(switched)
  );

  always #5 clk = ~clk;

  // Model: owner is the granted source, or -1 when nobody holds the mux.
  int owner = -1, m_sel = 0, m_cnt = 0, m_last = 3, m_sw = 0;
  int waits [4] = '{0, 0, 0, 0};
  bit model_live = 0;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    int o, s, c, l, w, sw;
    logic [3:0] oth;
    o = owner; s = m_sel; c = m_cnt; l = m_last; sw = 0;
    if (!rst_n) begin
      o = -1; s = 0; c = 0; l = 3;
    end else if (o < 0) begin
      if (req != 4'b0) begin
        w = first_from(req, l + 1);
        o = w; s = w; c = 1; l = w; sw = 1;
      end
    end else begin
      oth = req;
      oth[o] = 1'b0;
      if ((!req[o] || c >= MH) && oth != 4'b0) begin
        w = first_from(oth, o + 1);
        o = w; s = w; c = 1; l = w; sw = 1;
      end else if (!req[o]) begin
        o = -1; c = 0;
      end else if (c < MH) begin
        c = c + 1;
      end
    end
    owner <= o; m_sel <= s; m_cnt <= c; m_last <= l; m_sw <= sw;
    for (int i = 0; i < 4; i++)
      waits[i] <= (rst_n && req[i] && o != i) ? waits[i] + 1 : 0;
    model_live <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      chk("model_sel", 32'(sel), 32'(m_sel));
      chk("model_valid", 32'(valid), (owner >= 0) ? 32'd1 : 32'd0);
      chk("model_gnt", 32'(gnt), (owner >= 0) ? (32'd1 << owner) : 32'd0);
      chk("model_switched", 32'(switched), 32'(m_sw));
      for (int i = 0; i < 4; i++)
        chk("fairness_wait", (waits[i] > 3 * MH) ? 32'd1 : 32'd0, 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_switched", 32'(switched), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk("contend_sel", 32'(sel), 32'((k / 4) % 4));
      chk("contend_switched", 32'(switched), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("contend_valid", 32'(valid), 32'd1);
    end
    req = 4'b0000;
    @(negedge clk);
    chk("drain0_valid", 32'(valid), 32'd0);
    chk("drain0_sel", 32'(sel), 32'd0);
    req = 4'b0100;
    @(negedge clk);
    chk("single_sel", 32'(sel), 32'd2);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_valid", 32'(valid), 32'd1);
    chk("single_switched", 32'(switched), 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("single_hold_sel", 32'(sel), 32'd2);
      chk("single_hold_switched", 32'(switched), 32'd0);
    end
    req = 4'b0000;
    @(negedge clk);
    chk("drain_valid", 32'(valid), 32'd0);
    chk("drain_gnt", 32'(gnt), 32'd0);
    chk("drain_sel", 32'(sel), 32'd2);
    req = 4'b0001;
    @(negedge clk);
    chk("regrant_sel", 32'(sel), 32'd0);
    chk("regrant_switched", 32'(switched), 32'd1);
    req = 4'b0010;
    @(negedge clk);
    chk("handoff_sel", 32'(sel), 32'd1);
    chk("handoff_switched", 32'(switched), 32'd1);
    req = 4'b1000;
    @(negedge clk);
    chk("early_sel", 32'(sel), 32'd3);
    chk("early_valid", 32'(valid), 32'd1);
    chk("early_switched", 32'(switched), 32'd1);
    // Fresh hold count on source 3: three more cycles before rotating to 1.
    req = 4'b1010;
    repeat (3) begin
      @(negedge clk);
      chk("early_hold_sel", 32'(sel), 32'd3);
    end
    @(negedge clk);
    chk("early_rotate_sel", 32'(sel), 32'd1);
    chk("early_rotate_switched", 32'(switched), 32'd1);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    chk("pre_reset_sel", 32'(sel), 32'd2);
    rst_n = 1'b0;
    req   = 4'b0101;
    @(negedge clk);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_switched", 32'(switched), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_sel", 32'(sel), 32'd0);
    chk("postrst_gnt", 32'(gnt), 32'd1);
    chk("postrst_switched", 32'(switched), 32'd1);
    repeat (5) @(negedge clk);
    chk("postrst_rotate_sel", 32'(sel), 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
